// File: rtl/pc_redirect.sv
// Fetch PC register and control-flow redirect stage; MISALIGN_TRAP_EN enables the misaligned-target trap.
// Latency: an unstalled redirect reaches pc one cycle after req; flush is high for FLUSH_CYCLES cycles after that.
// Backpressure: stall holds pc, and a redirect that arrives during a stall is parked until the stall drops.
module pc_redirect #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        is_branch,
  input  logic        br_taken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] ex_pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1data,
  output logic [31:0] pc,
  output logic        flush,
  output logic        misalign
);

  localparam logic [2:0] SQUASH_INIT = 3'(FLUSH_CYCLES);

  logic [2:0]  squash_cnt;
  logic        pend_v;
  logic [31:0] pend_pc;
  logic        req;
  logic [31:0] raw_tgt;
  logic [31:0] tgt;
  logic        tgt_mis;
  logic        pend_mis;

  assign flush = (squash_cnt != 3'd0);

  // jal and branch share the pc-relative target, so only jalr needs priority.
  always_comb begin
    raw_tgt = jalr ? ((rs1data + imm) & ~32'h1) : (ex_pc + imm);
`ifdef MISALIGN_TRAP_EN
    tgt      = raw_tgt;
    tgt_mis  = raw_tgt[1];
    pend_mis = pend_pc[1];
`else
    tgt      = {raw_tgt[31:2], 2'b00};
    tgt_mis  = 1'b0;
    pend_mis = 1'b0;
`endif
  end

  // Wrong-path instructions behind a redirect are ignored while flush or a parked redirect is live.
  assign req = ex_valid & ~flush & ~pend_v & (jal | jalr | (is_branch & br_taken));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      misalign   <= 1'b0;
      squash_cnt <= 3'd0;
      pend_v     <= 1'b0;
      pend_pc    <= 32'h0;
    end else begin
      misalign <= 1'b0;
      if (stall) begin
        if (req) begin
          pend_pc    <= tgt;
          pend_v     <= 1'b1;
          squash_cnt <= SQUASH_INIT;
        end
      end else if (pend_v) begin
        pend_v     <= 1'b0;
        squash_cnt <= SQUASH_INIT;
        if (pend_mis) misalign <= 1'b1;
        else          pc       <= pend_pc;
      end else if (req) begin
        squash_cnt <= SQUASH_INIT;
        if (tgt_mis) misalign <= 1'b1;
        else         pc       <= tgt;
      end else begin
        pc <= pc + 32'd4;
        if (squash_cnt != 3'd0) squash_cnt <= squash_cnt - 3'd1;
      end
    end
  end

endmodule
